// File: rtl/gpio_port_array.sv
`default_nettype none
// ============================================================================
// Module      : gpio_port_array
// Description : NUM_PORTS x PORT_WIDTH GPIO block on the peripheral register
//               bus. Per-pin direction, atomic set/clear/toggle of the
//               output register, optional debounce filter on every input
//               and per-pin edge/level interrupts folded into one irq line
//               per port.
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_port_array #(
    parameter int NUM_PORTS  = 2,
    parameter int PORT_WIDTH = 32,
    parameter int DEB_W      = 8,
    parameter int ADDR_W     = $clog2(NUM_PORTS) + 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            reg_en,
    input  logic                            reg_we,
    input  logic [ADDR_W-1:0]               reg_addr,
    input  logic [31:0]                     reg_wdata,
    output logic [31:0]                     reg_rdata,
    output logic [NUM_PORTS-1:0]            irq,
    input  logic [NUM_PORTS*PORT_WIDTH-1:0] pin_in,
    output logic [NUM_PORTS*PORT_WIDTH-1:0] pin_out,
    output logic [NUM_PORTS*PORT_WIDTH-1:0] pin_oe
);

    // Port-index field width; a single-port build has no index bits at all.
    localparam int         c_PIDX_W       = (ADDR_W > 4) ? ADDR_W - 4 : 1;

    localparam logic [3:0] c_OFF_DATA_IN  = 4'h0;
    localparam logic [3:0] c_OFF_DATA_OUT = 4'h1;
    localparam logic [3:0] c_OFF_DIR      = 4'h2;
    localparam logic [3:0] c_OFF_OUT_SET  = 4'h3;
    localparam logic [3:0] c_OFF_OUT_CLR  = 4'h4;
    localparam logic [3:0] c_OFF_OUT_TGL  = 4'h5;
    localparam logic [3:0] c_OFF_INT_EN   = 4'h6;
    localparam logic [3:0] c_OFF_INT_TYPE = 4'h7;
    localparam logic [3:0] c_OFF_INT_POL  = 4'h8;
    localparam logic [3:0] c_OFF_INT_BOTH = 4'h9;
    localparam logic [3:0] c_OFF_INT_STAT = 4'hA;
    localparam logic [3:0] c_OFF_DEB_EN   = 4'hB;
    localparam logic [3:0] c_OFF_DEB_CNT  = 4'hC;

    logic [3:0]              w_off;
    logic [c_PIDX_W-1:0]     w_idx;
    logic [NUM_PORTS*32-1:0] w_rd_flat;
    logic [31:0]             w_rd_sel;
    logic [31:0]             r_rdata;
    logic                    w_unused;

    assign w_off     = reg_addr[3:0];
    assign reg_rdata = r_rdata;
    // Write-data bits above the port width are intentionally ignored.
    assign w_unused  = ^reg_wdata;

    generate
        if (ADDR_W > 4) begin : g_idx_multi
            assign w_idx = reg_addr[ADDR_W-1:4];
        end else begin : g_idx_single
            assign w_idx = 1'b0;
        end
    endgenerate

    generate
        for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
            localparam int c_LO = p * PORT_WIDTH;

            logic                  w_sel;
            logic                  w_wr;
            logic [PORT_WIDTH-1:0] w_wd;
            logic [PORT_WIDTH-1:0] r_data_out;
            logic [PORT_WIDTH-1:0] r_dir;
            logic [PORT_WIDTH-1:0] r_int_en;
            logic [PORT_WIDTH-1:0] r_int_type;
            logic [PORT_WIDTH-1:0] r_int_pol;
            logic [PORT_WIDTH-1:0] r_int_both;
            logic [PORT_WIDTH-1:0] r_int_stat;
            logic [PORT_WIDTH-1:0] r_deb_en;
            logic [DEB_W-1:0]      r_deb_cnt;
            logic [PORT_WIDTH-1:0] r_sync1;
            logic [PORT_WIDTH-1:0] r_sync2;
            logic [PORT_WIDTH-1:0] r_filt;
            logic [PORT_WIDTH-1:0] r_filt_d;
            logic [DEB_W-1:0]      r_cnt [PORT_WIDTH];
            logic [PORT_WIDTH-1:0] w_rise;
            logic [PORT_WIDTH-1:0] w_fall;
            logic [PORT_WIDTH-1:0] w_edge_hit;
            logic [PORT_WIDTH-1:0] w_lvl_hit;
            logic [PORT_WIDTH-1:0] w_hit;
            logic [PORT_WIDTH-1:0] w_w1c;
            logic                  r_irq;
            logic [31:0]           w_rd_val;

            // Out-of-range indices simply match no port.
            assign w_sel = (w_idx == c_PIDX_W'(p));
            assign w_wr  = reg_en & reg_we & w_sel;
            assign w_wd  = reg_wdata[PORT_WIDTH-1:0];
            assign w_w1c = (w_wr && (w_off == c_OFF_INT_STAT)) ? w_wd : '0;

            assign w_rise     = r_filt & ~r_filt_d;
            assign w_fall     = ~r_filt & r_filt_d;
            assign w_edge_hit = (r_int_both & (w_rise | w_fall)) |
                                (~r_int_both & ((r_int_pol & w_fall) | (~r_int_pol & w_rise)));
            assign w_lvl_hit  = (r_int_pol & r_filt) | (~r_int_pol & ~r_filt);
            assign w_hit      = r_int_en & ((r_int_type & w_lvl_hit) | (~r_int_type & w_edge_hit));

            // Control registers, sticky interrupt status and registered irq.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_data_out <= '0;
                    r_dir      <= '0;
                    r_int_en   <= '0;
                    r_int_type <= '0;
                    r_int_pol  <= '0;
                    r_int_both <= '0;
                    r_int_stat <= '0;
                    r_deb_en   <= '0;
                    r_deb_cnt  <= '0;
                    r_irq      <= 1'b0;
                end else begin
                    if (w_wr) begin
                        case (w_off)
                            c_OFF_DATA_OUT: r_data_out <= w_wd;
                            c_OFF_DIR:      r_dir      <= w_wd;
                            c_OFF_OUT_SET:  r_data_out <= r_data_out | w_wd;
                            c_OFF_OUT_CLR:  r_data_out <= r_data_out & ~w_wd;
                            c_OFF_OUT_TGL:  r_data_out <= r_data_out ^ w_wd;
                            c_OFF_INT_EN:   r_int_en   <= w_wd;
                            c_OFF_INT_TYPE: r_int_type <= w_wd;
                            c_OFF_INT_POL:  r_int_pol  <= w_wd;
                            c_OFF_INT_BOTH: r_int_both <= w_wd;
                            c_OFF_DEB_EN:   r_deb_en   <= w_wd;
                            c_OFF_DEB_CNT:  r_deb_cnt  <= reg_wdata[DEB_W-1:0];
                            default:        ;
                        endcase
                    end
                    // A new hit wins over a same-cycle write-1-to-clear.
                    r_int_stat <= (r_int_stat & ~w_w1c) | w_hit;
                    r_irq      <= |r_int_stat;
                end
            end

            // Two-flop synchroniser followed by the per-pin debounce filter.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_sync1  <= '0;
                    r_sync2  <= '0;
                    r_filt   <= '0;
                    r_filt_d <= '0;
                    for (int i = 0; i < PORT_WIDTH; i++) begin
                        r_cnt[i] <= '0;
                    end
                end else begin
                    r_sync1  <= pin_in[c_LO +: PORT_WIDTH];
                    r_sync2  <= r_sync1;
                    r_filt_d <= r_filt;
                    for (int i = 0; i < PORT_WIDTH; i++) begin
                        if (!r_deb_en[i]) begin
                            r_filt[i] <= r_sync2[i];
                        end else if (r_sync2[i] == r_filt[i]) begin
                            r_cnt[i] <= '0;
                        end else if (r_cnt[i] < r_deb_cnt) begin
                            r_cnt[i] <= r_cnt[i] + DEB_W'(1);
                        end else begin
                            // >= also covers DEB_CNT lowered below a running count.
                            r_filt[i] <= r_sync2[i];
                            r_cnt[i]  <= '0;
                        end
                    end
                end
            end

            // Read value of the addressed register within this port.
            always_comb begin
                w_rd_val = '0;
                case (w_off)
                    c_OFF_DATA_IN:  w_rd_val = 32'(r_filt);
                    c_OFF_DATA_OUT: w_rd_val = 32'(r_data_out);
                    c_OFF_DIR:      w_rd_val = 32'(r_dir);
                    c_OFF_INT_EN:   w_rd_val = 32'(r_int_en);
                    c_OFF_INT_TYPE: w_rd_val = 32'(r_int_type);
                    c_OFF_INT_POL:  w_rd_val = 32'(r_int_pol);
                    c_OFF_INT_BOTH: w_rd_val = 32'(r_int_both);
                    c_OFF_INT_STAT: w_rd_val = 32'(r_int_stat);
                    c_OFF_DEB_EN:   w_rd_val = 32'(r_deb_en);
                    c_OFF_DEB_CNT:  w_rd_val = 32'(r_deb_cnt);
                    default:        w_rd_val = '0;
                endcase
            end

            assign w_rd_flat[p*32 +: 32]       = w_rd_val;
            assign pin_out[c_LO +: PORT_WIDTH] = r_data_out;
            assign pin_oe[c_LO +: PORT_WIDTH]  = r_dir;
            assign irq[p]                      = r_irq;
        end
    endgenerate

    // Select the addressed port's read value; unknown ports read zero.
    always_comb begin
        w_rd_sel = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (w_idx == c_PIDX_W'(p)) begin
                w_rd_sel = w_rd_flat[p*32 +: 32];
            end
        end
    end

    // Read data register: updated only by a read access, held otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (reg_en && !reg_we) begin
            r_rdata <= w_rd_sel;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gpio_port_array.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpio_port_array
// Description : Directed self-checking bench for gpio_port_array. Reads are
//               checked through an expected-value queue drained by a monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpio_port_array;

    localparam int NP = 2;
    localparam int PW = 32;
    localparam int AW = 5;

    logic           clk = 1'b0;
    logic           rst;
    logic           reg_en;
    logic           reg_we;
    logic [AW-1:0]  reg_addr;
    logic [31:0]    reg_wdata;
    logic [31:0]    reg_rdata;
    logic [NP-1:0]  irq;
    logic [NP*PW-1:0] pin_in;
    logic [NP*PW-1:0] pin_out;
    logic [NP*PW-1:0] pin_oe;

    // Three-port, 8-bit instance used for the out-of-range port index.
    logic        r3_en;
    logic        r3_we;
    logic [5:0]  r3_addr;
    logic [31:0] r3_wdata;
    logic [31:0] r3_rdata;
    logic [2:0]  irq3;
    logic [23:0] pin_in3;
    logic [23:0] pin_out3;
    logic [23:0] pin_oe3;

    gpio_port_array #(.NUM_PORTS(NP), .PORT_WIDTH(PW), .DEB_W(8)) u_dut (
        .clk(clk), .rst(rst), .reg_en(reg_en), .reg_we(reg_we),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
        .irq(irq), .pin_in(pin_in), .pin_out(pin_out), .pin_oe(pin_oe)
    );

    gpio_port_array #(.NUM_PORTS(3), .PORT_WIDTH(8), .DEB_W(8)) u_dut3 (
        .clk(clk), .rst(rst), .reg_en(r3_en), .reg_we(r3_we),
        .reg_addr(r3_addr), .reg_wdata(r3_wdata), .reg_rdata(r3_rdata),
        .irq(irq3), .pin_in(pin_in3), .pin_out(pin_out3), .pin_oe(pin_oe3)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: a read accepted at a rising edge is compared at the next falling edge.
    initial begin : monitor
        logic v;
        exp_t e;
        forever begin
            @(posedge clk);
            v = reg_en && !reg_we && !rst;
            @(negedge clk);
            if (v) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_underflow: read data 0x%08h with nothing expected", reg_rdata);
                end else begin
                    e = sb_q.pop_front();
                    check(e.name, 64'(reg_rdata), 64'(e.exp));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // All tasks are entered and left on a falling edge.
    task automatic wr(input int port, input int off, input logic [31:0] data);
        reg_en    = 1'b1;
        reg_we    = 1'b1;
        reg_addr  = AW'(port * 16 + off);
        reg_wdata = data;
        @(negedge clk);
        reg_en = 1'b0;
        reg_we = 1'b0;
    endtask

    task automatic rd(input int port, input int off, input logic [31:0] exp, input string name);
        exp_t e;
        e.name = name;
        e.exp  = exp;
        sb_q.push_back(e);
        reg_en   = 1'b1;
        reg_we   = 1'b0;
        reg_addr = AW'(port * 16 + off);
        @(negedge clk);
        reg_en = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr3(input int port, input int off, input logic [31:0] data);
        r3_en    = 1'b1;
        r3_we    = 1'b1;
        r3_addr  = 6'(port * 16 + off);
        r3_wdata = data;
        @(negedge clk);
        r3_en = 1'b0;
        r3_we = 1'b0;
    endtask

    task automatic rd3(input int port, input int off, input logic [31:0] exp, input string name);
        r3_en   = 1'b1;
        r3_we   = 1'b0;
        r3_addr = 6'(port * 16 + off);
        @(negedge clk);
        r3_en = 1'b0;
        check(name, 64'(r3_rdata), 64'(exp));
    endtask

    initial begin : stimulus
        rst = 1'b1; reg_en = 1'b0; reg_we = 1'b0; reg_addr = '0; reg_wdata = '0;
        pin_in = '0;
        r3_en = 1'b0; r3_we = 1'b0; r3_addr = '0; r3_wdata = '0; pin_in3 = '0;
        tick(3);
        rst = 1'b0;

        // Reset state
        check("rst_irq", 64'(irq), 64'h0);
        check("rst_pin_oe", pin_oe, 64'h0);
        check("rst_pin_out", pin_out, 64'h0);
        check("rst_rdata", 64'(reg_rdata), 64'h0);
        for (int p = 0; p < 2; p++) begin
            for (int o = 0; o < 16; o++) begin
                rd(p, o, 32'h0, $sformatf("rst_rd_p%0d_o%0h", p, o));
            end
        end

        // Output register and atomic set/clear/toggle
        wr(0, 1, 32'h0000_00F0);
        check("out_data_out", 64'(pin_out[7:0]), 64'hF0);
        wr(0, 2, 32'h0000_00FF);
        check("out_dir", 64'(pin_oe[7:0]), 64'hFF);
        wr(0, 3, 32'h1);
        check("out_set", 64'(pin_out[7:0]), 64'hF1);
        wr(0, 4, 32'h10);
        check("out_clr", 64'(pin_out[7:0]), 64'hE1);
        wr(0, 5, 32'h3);
        check("out_tgl", 64'(pin_out[7:0]), 64'hE2);
        check("out_port1_untouched", 64'(pin_out[63:32]), 64'h0);
        rd(0, 1, 32'hE2, "rd_data_out");
        rd(0, 2, 32'hFF, "rd_dir");
        rd(0, 3, 32'h0, "rd_out_set_wo");
        wr(0, 4'hD, 32'hFFFF_FFFF);
        rd(0, 4'hD, 32'h0, "rd_reserved");
        rd(0, 1, 32'hE2, "rd_data_out_after_rsvd");

        // Port 1 pin 5 rising-edge interrupt
        wr(1, 6, 32'h20);
        pin_in[37] = 1'b1;
        tick(2);
        rd(1, 0, 32'h0, "edge_din_before");
        rd(1, 0, 32'h20, "edge_din_after");
        check("edge_irq_not_yet", 64'(irq[1]), 64'h0);
        rd(1, 4'hA, 32'h20, "edge_stat");
        check("edge_irq", 64'(irq[1]), 64'h1);
        wr(1, 4'hA, 32'h20);
        check("w1c_irq_lag", 64'(irq[1]), 64'h1);
        tick(1);
        check("w1c_irq", 64'(irq[1]), 64'h0);
        rd(1, 4'hA, 32'h0, "w1c_stat");
        pin_in[37] = 1'b0;
        tick(6);
        rd(1, 0, 32'h0, "fall_din");
        rd(1, 4'hA, 32'h0, "fall_no_int");
        check("fall_irq", 64'(irq), 64'h0);

        // Port 0 pin 0 debounce, DEB_CNT=3
        wr(0, 4'hB, 32'h1);
        wr(0, 4'hC, 32'h3);
        wr(0, 6, 32'h1);
        rd(0, 4'hC, 32'h3, "deb_cnt_rd");
        pin_in[0] = 1'b1;
        tick(3);
        pin_in[0] = 1'b0;
        tick(8);
        rd(0, 0, 32'h0, "deb_glitch_din");
        rd(0, 4'hA, 32'h0, "deb_glitch_no_int");
        check("deb_glitch_irq", 64'(irq[0]), 64'h0);
        pin_in[0] = 1'b1;
        tick(5);
        rd(0, 0, 32'h0, "deb_pulse_din_early");
        pin_in[0] = 1'b0;
        rd(0, 0, 32'h1, "deb_pulse_din");
        rd(0, 4'hA, 32'h1, "deb_pulse_int");
        check("deb_pulse_irq", 64'(irq[0]), 64'h1);
        tick(10);
        wr(0, 4'hA, 32'h1);
        tick(1);
        check("deb_w1c_irq", 64'(irq[0]), 64'h0);
        rd(0, 0, 32'h0, "deb_fall_din");

        // Port 0 pin 2 level-high interrupt
        wr(0, 7, 32'h4);
        wr(0, 8, 32'h4);
        wr(0, 6, 32'h4);
        pin_in[2] = 1'b1;
        tick(6);
        rd(0, 4'hA, 32'h4, "lvl_stat");
        check("lvl_irq", 64'(irq[0]), 64'h1);
        wr(0, 4'hA, 32'h4);
        rd(0, 4'hA, 32'h4, "lvl_stat_reasserts");
        check("lvl_irq_held", 64'(irq[0]), 64'h1);
        pin_in[2] = 1'b0;
        tick(5);
        rd(0, 0, 32'h0, "lvl_din_low");
        rd(0, 4'hA, 32'h4, "lvl_stat_sticky");
        wr(0, 4'hA, 32'h4);
        tick(1);
        check("lvl_w1c_irq", 64'(irq[0]), 64'h0);
        rd(0, 4'hA, 32'h0, "lvl_stat_clear");

        // Reset in the middle of a debounce count and a pending interrupt
        pin_in[37] = 1'b1;
        pin_in[0]  = 1'b1;
        rd(0, 2, 32'hFF, "pre_rst_dir");
        tick(4);
        check("pre_rst_irq", 64'(irq[1]), 64'h1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        pin_in[37] = 1'b0;
        pin_in[0]  = 1'b0;
        check("mid_rst_irq", 64'(irq), 64'h0);
        check("mid_rst_pin_out", pin_out, 64'h0);
        check("mid_rst_pin_oe", pin_oe, 64'h0);
        check("mid_rst_rdata", 64'(reg_rdata), 64'h0);
        rd(0, 0, 32'h0, "mid_rst_din_p0");
        rd(1, 0, 32'h0, "mid_rst_din_p1");
        rd(1, 4'hA, 32'h0, "mid_rst_stat_p1");
        rd(1, 6, 32'h0, "mid_rst_int_en_p1");
        rd(0, 1, 32'h0, "mid_rst_data_out");
        rd(0, 2, 32'h0, "mid_rst_dir");
        rd(0, 4'hB, 32'h0, "mid_rst_deb_en");
        rd(0, 4'hC, 32'h0, "mid_rst_deb_cnt");

        // Out-of-range port index on the three-port instance
        wr3(2, 1, 32'h0000_01A5);
        check("p2_pin_out", 64'(pin_out3[23:16]), 64'hA5);
        rd3(2, 1, 32'hA5, "p2_rd_mask");
        wr3(3, 1, 32'hFFFF_FFFF);
        wr3(3, 2, 32'hFFFF_FFFF);
        check("oor_pin_out", 64'(pin_out3), 64'h00A5_0000 >> 0 & 64'hA5_0000);
        check("oor_pin_oe", 64'(pin_oe3), 64'h0);
        rd3(3, 1, 32'h0, "oor_rd");
        rd3(2, 4'hD, 32'h0, "p2_reserved_rd");
        rd3(2, 1, 32'hA5, "p2_rd_after_oor");

        tick(2);
        check("sb_drained", 64'(sb_q.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
